// File: rtl/clk_sel_ctrl.sv
// Clock-source select controller: sequences glitch-free mux switches with a settle window.
// Optional macro CLK_SEL_AUTO_FALLBACK_EN enables forced fallback to clock A on b_fail.
//
// state  | meaning
// IDLE   | sel stable, requests may be accepted
// SETTLE | sel just changed, downstream mux settling; counter runs down to 0
module clk_sel_ctrl #(
  parameter int SETTLE_CYC = 16,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  input  logic             req_sel,
  output logic             req_ready,
  input  logic             b_fail,
  input  logic             fault_clr,
  output logic             sel,
  output logic             busy,
  output logic             done,
  output logic             fault_flag,
  output logic [CNT_W-1:0] switch_cnt
);

  typedef enum logic {IDLE = 1'b0, SETTLE = 1'b1} state_t;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYC - 1);

  state_t           state_q, state_d;
  logic             sel_q, sel_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] swc_q, swc_d;
  logic             fault_q, fault_d;
  logic             pend_q, pend_d;
  logic             fb_go;
  logic             accept;

`ifdef CLK_SEL_AUTO_FALLBACK_EN
  // pend_q can only be set while settling towards B, so in IDLE it implies sel_q = 1
  assign fb_go   = (state_q == IDLE) && sel_q && (b_fail || pend_q);
  assign pend_d  = (state_q == SETTLE) ? (pend_q | (sel_q & b_fail)) : 1'b0;
  assign fault_d = fb_go | (fault_q & ~fault_clr);
`else
  logic unused_fb;
  assign fb_go     = 1'b0;
  assign pend_d    = 1'b0;
  assign fault_d   = 1'b0;
  assign unused_fb = b_fail ^ fault_clr ^ pend_q;
`endif

  assign req_ready = (state_q == IDLE) && !fb_go;
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fb_go) begin
          sel_d   = 1'b0;
          cnt_d   = SETTLE_LOAD;
          state_d = SETTLE;
        end else if (accept && (req_sel != sel_q) && !(fault_q && req_sel)) begin
          sel_d   = req_sel;
          cnt_d   = SETTLE_LOAD;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == 8'd0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    swc_d = (done_d && (swc_q != {CNT_W{1'b1}})) ? swc_q + CNT_W'(1) : swc_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      cnt_q   <= 8'd0;
      done_q  <= 1'b0;
      swc_q   <= '0;
      fault_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      swc_q   <= swc_d;
      fault_q <= fault_d;
      pend_q  <= pend_d;
    end
  end

  assign sel        = sel_q;
  assign busy       = (state_q == SETTLE);
  assign done       = done_q;
  assign fault_flag = fault_q;
  assign switch_cnt = swc_q;

endmodule

// File: doc/clk_sel_ctrl.md
CLK_SEL_CTRL -- requirements
Module: clk_sel_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 16, meaning cycles ready stays low after a sel change; legal range 2..255.
REQ-002 SHALL have parameter CNT_W, default 8, meaning width of switch_cnt.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rstn  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port req_valid  input  1  switch request valid.
REQ-006 SHALL have port req_sel  input  1  requested source: 0 = clock A, 1 = clock B.
REQ-007 SHALL have port req_ready  output  1  request accepted when req_valid & req_ready at a rising edge.
REQ-008 SHALL have port b_fail  input  1  clock-B-lost indication, already synchronous to clk.
REQ-009 SHALL have port fault_clr  input  1  clears fault_flag.
REQ-010 SHALL have port sel  output  1  registered select driving the downstream glitch-free clock mux.
REQ-011 SHALL have port busy  output  1  high while settling.
REQ-012 SHALL have port done  output  1  one-cycle pulse at settle end.
REQ-013 SHALL have port fault_flag  output  1  sticky forced-fallback indicator.
REQ-014 SHALL have port switch_cnt  output  CNT_W  count of completed source changes.

Function
REQ-015 SHALL implement FSM states IDLE and SETTLE; req_ready = (state == IDLE) and no fallback pending.
REQ-016 In IDLE, an accepted request with req_sel != sel SHALL load sel <= req_sel, load the settle counter with SETTLE_CYC-1, and go to SETTLE on the same edge.
REQ-017 An accepted request with req_sel == sel SHALL be consumed with no sel change, no SETTLE entry, no done, and no switch_cnt change.
REQ-018 In SETTLE, the counter SHALL decrement each cycle, busy = 1, and req_ready = 0; at counter 0 the FSM SHALL return to IDLE and assert done for exactly one cycle.
REQ-019 busy SHALL therefore be high for exactly SETTLE_CYC cycles per switch, and sel SHALL be stable throughout SETTLE.
REQ-020 switch_cnt SHALL increment by 1 on each done and saturate at all-ones (no wrap).
REQ-021 req_valid while req_ready = 0 SHALL be ignored; the requester holds it until accepted.
REQ-022 fault_clr and a fallback-setting event in the same cycle: set SHALL win.

Reset
REQ-023 On rstn = 0 at a clock edge: state = IDLE, sel = 0 (clock A, matching the downstream mux reset default), settle counter = 0, busy = 0, done = 0, fault_flag = 0, switch_cnt = 0, and the pending latch is cleared.
REQ-024 Reset asserted during SETTLE SHALL abort settling with no done pulse; req_ready = 1 in the first cycle after reset release.

Configuration
REQ-025 Macro CLK_SEL_AUTO_FALLBACK_EN SHALL gate automatic fallback.
REQ-026 With the macro defined:
- b_fail = 1 while sel = 1 in IDLE SHALL force sel <= 0, enter SETTLE, set fault_flag, and drop req_ready in the same cycle; a simultaneous req_valid is not accepted.
- b_fail seen during SETTLE SHALL be latched as pending and acted on in the first IDLE cycle.
- While fault_flag = 1, requests with req_sel = 1 SHALL be consumed as no-ops.
REQ-027 Without the macro, b_fail and fault_clr SHALL be ignored and fault_flag SHALL be constant 0.

Verification
REQ-028 Reset, then req_valid = 1, req_sel = 1 for one cycle -> sel = 1 after that edge; busy high 16 cycles; done pulses once; switch_cnt = 1; req_ready returns to 1.
REQ-029 sel = 0, request req_sel = 0 -> accepted in one cycle; sel, busy, done, and switch_cnt all unchanged.
REQ-030 req_valid held high during SETTLE with req_sel = 0 -> not accepted until IDLE, then a second 16-cycle settle; switch_cnt = 2.
REQ-031 rstn low at settle cycle 5 -> sel = 0, busy = 0, no done; switch_cnt = 0 after release.
REQ-032 (with CLK_SEL_AUTO_FALLBACK_EN) sel = 1 with b_fail pulsed at settle cycle 3 -> after settle ends, forced sel = 0 and fault_flag = 1; a later req_sel = 1 is a no-op until fault_clr.
REQ-033 Force switch_cnt to 255, then perform a switch -> switch_cnt stays 255.
